// File: rtl/tx_word_serializer.sv
// Breaks a WORD_BYTES-wide result word into bytes and hands them to a UART transmitter one frame at a time.
// Every output is a flop, so a request pulse appears in the cycle after ISSUE saw the transmitter idle.
module tx_word_serializer #(
  parameter int unsigned WORD_BYTES = 8,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    i_word_valid,
  input  logic [8*WORD_BYTES-1:0] i_word,
  output logic                    o_word_ready,
  output logic                    o_data_avail,
  output logic [7:0]              o_data_byte,
  input  logic                    i_tx_active,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic                    o_word_done
);

  localparam int unsigned W         = 8 * WORD_BYTES;
  localparam int unsigned CW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [W-1:0]  shreg;
  logic [7:0]    send_byte;
  logic [W-1:0]  shreg_next;

  // The byte to send always sits at the send end of the register; shifting moves the next one there.
  always_comb begin
    send_byte  = MSB_FIRST ? shreg[W-1 -: 8] : shreg[7:0];
    shreg_next = MSB_FIRST ? (shreg << 8) : (shreg >> 8);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      shreg        <= '0;
      o_data_avail <= 1'b0;
      o_data_byte  <= '0;
      o_word_done  <= 1'b0;
      o_busy       <= 1'b0;
      o_word_ready <= 1'b0;
    end else begin
      o_data_avail <= 1'b0;
      o_word_done  <= 1'b0;
      case (state)
        IDLE: begin
          o_word_ready <= 1'b1;
          if (i_word_valid && o_word_ready) begin
            shreg        <= i_word;
            byte_cnt     <= '0;
            state        <= ISSUE;
            o_word_ready <= 1'b0;
            o_busy       <= 1'b1;
          end
        end
        ISSUE: begin
          if (!i_tx_active) begin
            o_data_avail <= 1'b1;
            o_data_byte  <= send_byte;
            state        <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_tx_done) begin
            shreg <= shreg_next;
            // The counter stops at the last index instead of wrapping past it.
            if (byte_cnt == LAST_IDX) begin
              state       <= FINISH;
              o_word_done <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              state    <= ISSUE;
            end
          end
        end
        FINISH: begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_word_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_word_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Three serializers (4-byte LSB-first, 4-byte MSB-first, 1-byte) share stimulus; each has its own
// transmitter model and a queue-based reference of the bytes the word should produce.
module tb_tx_word_serializer;

  localparam int unsigned NDUT = 3;

  logic        clock        = 1'b0;
  logic        reset_n      = 1'b0;
  logic        word_valid   = 1'b0;
  logic [31:0] word_bus     = '0;
  logic        hold_act     = 1'b0;
  logic        force_done   = 1'b0;
  logic        fixed_frames = 1'b1;

  logic        ready_o  [NDUT];
  logic        avail_o  [NDUT];
  logic        busy_o   [NDUT];
  logic        done_o   [NDUT];
  logic [7:0]  byte_o   [NDUT];
  logic [7:0]  cur_exp  [NDUT];
  logic        tx_act   [NDUT];
  logic        tx_done  [NDUT];
  logic        mdl_act  [NDUT];
  logic        mdl_done [NDUT];
  logic        inflight [NDUT];
  logic        pend     [NDUT];
  int unsigned qsz      [NDUT];
  int unsigned avail_cnt[NDUT];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int unsigned WB  = (k == 2) ? 1 : 4;
    localparam bit          MSB = (k == 1);

    assign tx_act[k]  = hold_act | mdl_act[k];
    assign tx_done[k] = force_done | mdl_done[k];

    tx_word_serializer #(.WORD_BYTES(WB), .MSB_FIRST(MSB)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_word_valid (word_valid),
      .i_word       (word_bus[8*WB-1:0]),
      .o_word_ready (ready_o[k]),
      .o_data_avail (avail_o[k]),
      .o_data_byte  (byte_o[k]),
      .i_tx_active  (tx_act[k]),
      .i_tx_done    (tx_done[k]),
      .o_busy       (busy_o[k]),
      .o_word_done  (done_o[k])
    );

    // Transmitter: a request starts a frame of fixed or random length ending in a one-cycle done.
    initial begin : txm
      int cnt;
      cnt = 0;
      mdl_act[k]  = 1'b0;
      mdl_done[k] = 1'b0;
      inflight[k] = 1'b0;
      forever begin
        @(negedge clock);
        mdl_done[k] = 1'b0;
        if (!reset_n) begin
          mdl_act[k]  = 1'b0;
          inflight[k] = 1'b0;
          cnt = 0;
        end else if (mdl_act[k]) begin
          cnt--;
          if (cnt <= 0) begin
            mdl_act[k]  = 1'b0;
            mdl_done[k] = 1'b1;
            inflight[k] = 1'b0;
            check_eq($sformatf("byte_held%0d", k), 32'(byte_o[k]), 32'(cur_exp[k]));
          end
        end else if (avail_o[k]) begin
          mdl_act[k]  = 1'b1;
          inflight[k] = 1'b1;
          cnt = fixed_frames ? 10 : int'($urandom_range(1, 12));
        end
      end
    end

    // Reference: an accepted word becomes WB expected bytes; each request must take the next one.
    initial begin : mon
      logic [7:0]  q[$];
      logic [7:0]  e;
      logic        rdy_prev;
      logic        rdy_exp;
      int unsigned since_rst;
      rdy_prev = 1'b0;
      since_rst = 0;
      pend[k] = 1'b0;
      qsz[k] = 0;
      avail_cnt[k] = 0;
      cur_exp[k] = '0;
      forever begin
        @(posedge clock);
        #1;
        if (!reset_n) begin
          q.delete();
          pend[k] = 1'b0;
          since_rst = 0;
          rdy_prev = 1'b0;
        end else begin
          if (since_rst < 2) since_rst++;
          if (rdy_prev && word_valid) begin
            for (int i = 0; i < int'(WB); i++)
              q.push_back(word_bus[8*(MSB ? int'(WB)-1-i : i) +: 8]);
            pend[k] = 1'b1;
          end
          rdy_exp = !pend[k] && (since_rst >= 1);
          check_eq($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(pend[k]));
          check_eq($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(rdy_exp));
          if (avail_o[k]) begin
            avail_cnt[k]++;
            check_eq($sformatf("req_while_active%0d", k), 32'(tx_act[k]), 32'd0);
            check_eq($sformatf("req_overlap%0d", k), 32'(inflight[k]), 32'd0);
            check_eq($sformatf("req_expected%0d", k), 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
              e = q.pop_front();
              cur_exp[k] = e;
              check_eq($sformatf("req_byte%0d", k), 32'(byte_o[k]), 32'(e));
            end
          end
          if (done_o[k]) begin
            check_eq($sformatf("done_pending%0d", k), 32'(pend[k]), 32'd1);
            check_eq($sformatf("done_bytes_left%0d", k), 32'(q.size()), 32'd0);
            check_eq($sformatf("done_inflight%0d", k), 32'(inflight[k]), 32'd0);
            pend[k] = 1'b0;
          end
          rdy_prev = rdy_exp;
        end
        qsz[k] = q.size();
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(negedge clock);
    word_bus   = w;
    word_valid = 1'b1;
    @(negedge clock);
    word_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(negedge clock);
      idle = 1'b1;
      for (int k = 0; k < NDUT; k++)
        if (pend[k] || qsz[k] != 0 || inflight[k]) idle = 1'b0;
    end
    check_eq("wait_idle", 32'(idle), 32'd1);
  endtask

  task automatic check_reset_outputs(input string when);
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("%s_ready%0d", when, k), 32'(ready_o[k]), 32'd0);
      check_eq($sformatf("%s_avail%0d", when, k), 32'(avail_o[k]), 32'd0);
      check_eq($sformatf("%s_byte%0d", when, k), 32'(byte_o[k]), 32'd0);
      check_eq($sformatf("%s_busy%0d", when, k), 32'(busy_o[k]), 32'd0);
      check_eq($sformatf("%s_done%0d", when, k), 32'(done_o[k]), 32'd0);
    end
  endtask

  initial begin
    int unsigned base;
    logic        reached;

    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("ready_before_edge%0d", k), 32'(ready_o[k]), 32'd0);

    fixed_frames = 1'b1;
    send(32'hA1B2C3D4);
    wait_idle();

    // Transmitter busy while the word arrives, plus a stray done and a second word during the wait.
    @(negedge clock);
    hold_act = 1'b1;
    send(32'h5A6B7C8D);
    word_bus   = '1;
    word_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      force_done = (i == 4);
      if (i == 8) word_valid = 1'b0;
    end
    hold_act = 1'b0;
    @(posedge clock);
    #1;
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("issue_after_release%0d", k), 32'(avail_o[k]), 32'd1);
    wait_idle();

    // Abandon a word during its second byte.
    base = avail_cnt[0];
    send(32'h11223344);
    reached = 1'b0;
    for (int i = 0; i < 500 && !reached; i++) begin
      @(negedge clock);
      if (avail_cnt[0] >= base + 2) reached = 1'b1;
    end
    check_eq("reach_byte2", 32'(reached), 32'd1);
    repeat (3) @(negedge clock);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("mid_word");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("ready_after_release%0d", k), 32'(ready_o[k]), 32'd0);
    send(32'h00000055);
    wait_idle();

    // Random traffic with random frame lengths; the first stretch holds valid high for back-to-back words.
    fixed_frames = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      word_valid = (i < 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
      word_bus   = $urandom;
    end
    @(negedge clock);
    word_valid = 1'b0;
    wait_idle();
    for (int k = 0; k < NDUT; k++)
      check_eq($sformatf("final_pending%0d", k), 32'(pend[k]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_word_serializer.md
TX_WORD_SERIALIZER -- requirements
Module: tx_word_serializer

Interface
REQ-001 Parameter WORD_BYTES, default 8: number of bytes per result word; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends byte 0 (bits 7:0) first; 1 sends the most significant byte first.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_word_valid  input  1  upstream word is present on i_word.
REQ-006 i_word  input  8*WORD_BYTES  result word to be transmitted.
REQ-007 o_word_ready  output  1  block can accept a word this cycle.
REQ-008 o_data_avail  output  1  one-cycle request to the UART transmitter to start a byte.
REQ-009 o_data_byte  output  8  byte presented to the UART transmitter; stable from request until that byte's done.
REQ-010 i_tx_active  input  1  UART transmitter busy with a frame.
REQ-011 i_tx_done  input  1  UART transmitter one-cycle frame-complete pulse.
REQ-012 o_busy  output  1  a word is held and not yet fully transmitted.
REQ-013 o_word_done  output  1  one-cycle pulse after the last byte of a word completes.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_DONE, FINISH, with 2-bit encoding and a default arm returning to IDLE.
REQ-015 IDLE: o_word_ready=1; on i_word_valid=1, capture i_word into an internal shift register, clear byte counter to 0, go to ISSUE.
REQ-016 A transfer SHALL occur only on a cycle with i_word_valid=1 and o_word_ready=1; o_word_ready SHALL be 0 in every state except IDLE.
REQ-017 ISSUE: if i_tx_active=0, assert o_data_avail for exactly this cycle with o_data_byte equal to the current byte, then go to WAIT_DONE; if i_tx_active=1, hold in ISSUE with o_data_avail=0.
REQ-018 WAIT_DONE: o_data_avail=0 and o_data_byte held; on i_tx_done=1, increment byte counter and shift the register by 8 bits toward the send end.
REQ-019 WAIT_DONE on i_tx_done=1: if counter equals WORD_BYTES-1, go to FINISH; otherwise go to ISSUE.
REQ-020 A new byte request SHALL be issued no earlier than the cycle after i_tx_done was sampled high.
REQ-021 FINISH: pulse o_word_done=1 for one cycle, then go to IDLE; o_word_ready SHALL remain 0 in FINISH.
REQ-022 o_busy SHALL be 1 in ISSUE, WAIT_DONE and FINISH, and 0 in IDLE.
REQ-023 Byte counter width SHALL be ceil(log2(WORD_BYTES)) bits (minimum 1) and SHALL never exceed WORD_BYTES-1.
REQ-024 MSB_FIRST=0: bytes leave in order i_word[7:0], [15:8], ...; MSB_FIRST=1: reverse order.
REQ-025 i_tx_done=1 outside WAIT_DONE SHALL be ignored; i_word_valid outside IDLE SHALL be ignored and the held word unaffected.
REQ-026 WORD_BYTES=1: ISSUE, then WAIT_DONE, then FINISH, with exactly one request.
REQ-027 Per-word overhead SHALL be one cycle for ISSUE per byte plus one cycle for FINISH, in addition to transmitter frame time.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, counter 0, shift register 0, o_data_avail=0, o_data_byte=8'h00, o_word_done=0, o_busy=0, o_word_ready=0.
REQ-030 o_word_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-031 Reset asserted mid-word SHALL abandon the word with no o_word_done pulse and no further o_data_avail.

Verification
REQ-032 WORD_BYTES=4, MSB_FIRST=0, word 32'hA1B2C3D4, transmitter model with 10-cycle frames -> requests carry D4, C3, B2, A1 in order, then one o_word_done pulse.
REQ-033 Same word with MSB_FIRST=1 -> requests carry A1, B2, C3, D4.
REQ-034 i_tx_active held 1 for 20 cycles when ISSUE is entered -> o_data_avail stays 0 until the cycle after i_tx_active falls, then pulses once.
REQ-035 Second i_word_valid with 32'hFFFFFFFF while busy, plus spurious i_tx_done pulse in ISSUE -> both ignored; only the first word is sent and the byte count is unchanged.
REQ-036 reset_n pulsed low during byte 2 of 4 -> outputs hit reset values asynchronously, no o_word_done; o_word_ready=1 one edge after release; next word 32'h00000055 sends 55,00,00,00.
REQ-037 Back-to-back words with i_word_valid held high -> second word accepted in the IDLE cycle after FINISH, with no lost or duplicated byte.
